// File: rtl/cxl_pkg.sv
// cxl_pkg: shared widths, event record, dispatcher state encoding and the
// saturating adder used when coalescing events (build option CXL_COALESCE_EN).
package cxl_pkg;

  localparam int CLIENT_W = 5;
  localparam int AMOUNT_W = 16;

  typedef struct packed {
    logic [CLIENT_W-1:0] client_id;
    logic [AMOUNT_W-1:0] amount;
  } cxl_event_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE
  } cxl_state_t;

  // Amount addition that clamps at all-ones instead of wrapping.
  function automatic logic [AMOUNT_W-1:0] sat_add(input logic [AMOUNT_W-1:0] a,
                                                  input logic [AMOUNT_W-1:0] b);
    logic [AMOUNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[AMOUNT_W] ? {AMOUNT_W{1'b1}} : sum[AMOUNT_W-1:0];
  endfunction

endpackage

// File: rtl/cxl_if.sv
// cxl_if: cancel-event input handshake plus the registered issue bus toward
// the accumulator. The dispatcher uses the slave modport, its driver the master.
interface cxl_if;
  import cxl_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CLIENT_W-1:0] in_client_id;
  logic [AMOUNT_W-1:0] in_amount;
  logic [CLIENT_W-1:0] client_id;
  logic [AMOUNT_W-1:0] amount;
  logic                out_valid;
  logic                busy;
  logic [15:0]         dispatched_cnt;

  modport slave (
    input  in_valid, in_client_id, in_amount,
    output in_ready, client_id, amount, out_valid, busy, dispatched_cnt
  );

  modport master (
    output in_valid, in_client_id, in_amount,
    input  in_ready, client_id, amount, out_valid, busy, dispatched_cnt
  );

endinterface

// File: rtl/cxl_fifo.sv
// cxl_fifo: small circular buffer of cancel events with occupancy count.
// With CXL_COALESCE_EN a merge request folds the pushed amount into the
// newest entry (saturating) instead of allocating a new slot.
module cxl_fifo
  import cxl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  cxl_event_t                 push_data,
  input  logic                       pop,
`ifdef CXL_COALESCE_EN
  input  logic                       merge,
  output cxl_event_t                 tail,
`endif
  output cxl_event_t                 head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cxl_event_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            alloc;

`ifdef CXL_COALESCE_EN
  logic            merge_wr;
  assign merge_wr = push && merge;
  assign alloc    = push && !merge;
  assign tail     = mem[wr_ptr - PW'(1)];
`else
  assign alloc    = push;
`endif

  assign head = mem[rd_ptr];

  // Pointers and count; reset empties the buffer without touching storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  // Storage writes: new slot on allocation, in-place update on a merge.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem[wr_ptr] <= push_data;
    end
`ifdef CXL_COALESCE_EN
    else if (merge_wr) begin
      mem[wr_ptr - PW'(1)] <= '{client_id: tail.client_id,
                                 amount:    sat_add(tail.amount, push_data.amount)};
    end
`endif
  end

endmodule

// File: rtl/cxl_dispatch.sv
// cxl_dispatch: buffers cancel events and issues them one at a time, holding
// each on client_id/amount for the accumulator's read-modify-write window.
// Build option CXL_COALESCE_EN merges a push into a same-client tail entry.
module cxl_dispatch
  import cxl_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic reset,
  cxl_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  cxl_state_t          state;
  cxl_state_t          state_next;
  logic [SW-1:0]       settle_cnt;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  logic                has_data;
  cxl_event_t          head;
  cxl_event_t          push_data;
  logic [CLIENT_W-1:0] client_id;
  logic [AMOUNT_W-1:0] amount;
  logic [15:0]         dispatched_cnt;

  // Readiness comes only from the registered count, so no input-to-ready path.
  assign bus.in_ready = (count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign has_data     = (count != '0);
  assign push_data    = '{client_id: bus.in_client_id, amount: bus.in_amount};

`ifdef CXL_COALESCE_EN
  cxl_event_t tail;
  logic       merge;
  // A sole entry leaving this edge cannot absorb the push; it gets a new slot.
  assign merge = has_data && (tail.client_id == bus.in_client_id) &&
                 !(pop && (count == CW'(1)));
`endif

  cxl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
`ifdef CXL_COALESCE_EN
    .merge     (merge),
    .tail      (tail),
`endif
    .head      (head),
    .count     (count)
  );

  // State register plus the settle-window counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ISSUE)       settle_cnt <= '0;
      else if (state == SETTLE) settle_cnt <= settle_cnt + SW'(1);
    end
  end

  // Next state and pop decision; a settle window may chain straight into ISSUE.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (has_data) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = SETTLE;
      SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
          if (has_data) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue registers change only on a pop; the counter ticks once per ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      client_id      <= '0;
      amount         <= '0;
      dispatched_cnt <= '0;
    end else begin
      if (pop) begin
        client_id <= head.client_id;
        amount    <= head.amount;
      end
      if (state == ISSUE) dispatched_cnt <= dispatched_cnt + 16'd1;
    end
  end

  assign bus.client_id      = client_id;
  assign bus.amount         = amount;
  assign bus.out_valid      = (state == ISSUE);
  assign bus.busy           = (state != IDLE);
  assign bus.dispatched_cnt = dispatched_cnt;

endmodule

// File: tb/tb_cxl_dispatch.sv
// tb_cxl_dispatch: directed and random cancel-event traffic against a
// queue-based reference model (honours CXL_COALESCE_EN when defined).
module tb_cxl_dispatch;
  import cxl_pkg::*;

  localparam int DEPTH      = 4;
  localparam int SETTLE_CYC = 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cxl_if bus ();

  cxl_dispatch #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model: pending events, edge index of the most recent issue,
  // and the expected registered outputs.
  cxl_event_t          m_q [$];
  int                  m_edge;
  int                  m_last_pop;
  logic [CLIENT_W-1:0] m_client;
  logic [AMOUNT_W-1:0] m_amount;
  logic                m_ov;
  logic                m_busy;
  logic [15:0]         m_cnt;

  int   tests;
  int   failed;
  logic last_accept;
  int   ready_low_seen;
  int   watch_client;
  int   watch_n;
  int   watch_first;
  int   watch_last;
  int   tries;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last_pop = -1000;
    m_client   = '0;
    m_amount   = '0;
    m_ov       = 1'b0;
    m_busy     = 1'b0;
    m_cnt      = '0;
  endtask

  task automatic watch_clear(input int client);
    watch_client = client;
    watch_n      = 0;
    watch_first  = -1;
    watch_last   = -1;
  endtask

  // One clock of traffic: drive, check readiness, advance model, check outputs.
  task automatic apply_stimulus(input logic v, input logic [CLIENT_W-1:0] id,
                                input logic [AMOUNT_W-1:0] amt);
    logic       will_pop;
    logic       accept;
    logic       do_merge;
    cxl_event_t ev;
    int         s;
    bus.in_valid     = v;
    bus.in_client_id = id;
    bus.in_amount    = amt;
    #1;
    check_output("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
    if (!bus.in_ready) ready_low_seen++;
    will_pop = (m_q.size() > 0) && ((m_edge - m_last_pop) >= (1 + SETTLE_CYC));
    accept   = v && (m_q.size() < DEPTH);
    do_merge = 1'b0;
`ifdef CXL_COALESCE_EN
    do_merge = accept && (m_q.size() > 0) && (m_q[m_q.size()-1].client_id == id) &&
               !(will_pop && (m_q.size() == 1));
`endif
    @(posedge clk);
    if (m_last_pop == m_edge - 1) m_cnt++;
    m_ov = 1'b0;
    if (will_pop) begin
      ev         = m_q.pop_front();
      m_client   = ev.client_id;
      m_amount   = ev.amount;
      m_ov       = 1'b1;
      m_last_pop = m_edge;
    end
    if (accept) begin
      if (do_merge) begin
        ev = m_q[m_q.size()-1];
        s  = int'(ev.amount) + int'(amt);
        if (s > 65535) s = 65535;
        ev.amount = 16'(s);
        m_q[m_q.size()-1] = ev;
      end else begin
        ev.client_id = id;
        ev.amount    = amt;
        m_q.push_back(ev);
      end
    end
    m_busy = ((m_edge - m_last_pop) <= SETTLE_CYC);
    m_edge++;
    last_accept = accept;
    #1;
    check_output("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check_output("busy", 32'(bus.busy), 32'(m_busy));
    check_output("client_id", 32'(bus.client_id), 32'(m_client));
    check_output("amount", 32'(bus.amount), 32'(m_amount));
    check_output("dispatched_cnt", 32'(bus.dispatched_cnt), 32'(m_cnt));
    if (bus.out_valid && (int'(bus.client_id) == watch_client)) begin
      watch_n++;
      if (watch_first < 0) watch_first = int'(bus.amount);
      watch_last = int'(bus.amount);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0);
  endtask

  // Assert reset with a valid event on the inputs; everything must clear.
  task automatic apply_reset();
    bus.in_valid     = 1'b1;
    bus.in_client_id = 5'd9;
    bus.in_amount    = 16'h1234;
    #1 reset = 1'b1;
    #1;
    check_output("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_async_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_client_id", 32'(bus.client_id), 32'd0);
    check_output("rst_amount", 32'(bus.amount), 32'd0);
    check_output("rst_dispatched_cnt", 32'(bus.dispatched_cnt), 32'd0);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    model_reset();
  endtask

  initial begin
    tests          = 0;
    failed         = 0;
    m_edge         = 0;
    reset          = 1'b1;
    ready_low_seen = 0;
    bus.in_valid     = 1'b0;
    bus.in_client_id = '0;
    bus.in_amount    = '0;
    model_reset();
    watch_clear(-1);
    @(posedge clk);

    // Reset with in_valid held high, then quiet cycles.
    apply_reset();
    idle_cycles(3);

    // Single event into an empty buffer.
    watch_clear(3);
    apply_stimulus(1'b1, 5'd3, 16'd100);
    idle_cycles(4);
    check_output("single_issues", 32'(watch_n), 32'd1);
    check_output("single_amount", 32'(watch_last), 32'd100);
    check_output("single_cnt", 32'(bus.dispatched_cnt), 32'd1);

    // Back-to-back distinct events: enough to fill the buffer and stall input.
    ready_low_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tries = 0;
      do begin
        apply_stimulus(1'b1, 5'(10 + i), 16'(1000 * i + 1));
        tries++;
      end while (!last_accept && tries < 20);
      check_output("burst_accept", 32'(last_accept), 32'd1);
    end
    idle_cycles(14);
    check_output("burst_ready_dropped", 32'(ready_low_seen > 0), 32'd1);
    check_output("burst_cnt", 32'(bus.dispatched_cnt), 32'd9);

    // Three client-7 events queued behind other traffic.
    watch_clear(7);
    apply_stimulus(1'b1, 5'd9, 16'd1);
    apply_stimulus(1'b1, 5'd8, 16'd1);
    apply_stimulus(1'b1, 5'd7, 16'd10);
    apply_stimulus(1'b1, 5'd7, 16'd20);
    apply_stimulus(1'b1, 5'd7, 16'hFFF0);
    idle_cycles(10);
`ifdef CXL_COALESCE_EN
    check_output("coalesce_issues", 32'(watch_n), 32'd1);
    check_output("coalesce_amount", 32'(watch_last), 32'hFFFF);
`else
    check_output("coalesce_issues", 32'(watch_n), 32'd3);
    check_output("coalesce_amount", 32'(watch_last), 32'hFFF0);
`endif

    // Same-client push on the edge that pops the only entry.
    watch_clear(5);
    apply_stimulus(1'b1, 5'd5, 16'd1);
    apply_stimulus(1'b1, 5'd5, 16'd2);
    idle_cycles(6);
    check_output("tailpop_issues", 32'(watch_n), 32'd2);
    check_output("tailpop_first", 32'(watch_first), 32'd1);
    check_output("tailpop_second", 32'(watch_last), 32'd2);

    // Reset while settling with three events buffered.
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, 5'(20 + i), 16'(i));
    apply_reset();
    idle_cycles(4);
    watch_clear(2);
    apply_stimulus(1'b1, 5'd2, 16'd55);
    idle_cycles(4);
    check_output("post_reset_issues", 32'(watch_n), 32'd1);
    check_output("post_reset_amount", 32'(watch_last), 32'd55);
    check_output("post_reset_cnt", 32'(bus.dispatched_cnt), 32'd1);

    // Random traffic over a few clients so merges and stalls both occur.
    watch_clear(-1);
    for (int i = 0; i < 400; i++) begin
      logic [AMOUNT_W-1:0] amt;
      if ($urandom_range(0, 3) == 0) amt = 16'($urandom_range(16'hF000, 16'hFFFF));
      else                           amt = 16'($urandom_range(0, 500));
      apply_stimulus($urandom_range(0, 9) < 6, 5'($urandom_range(0, 3)), amt);
    end
    idle_cycles(20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
